// File: rtl/operand_save_bank.sv
// ---------------------------------------------------------------------------
// operand_save_bank
//
// Operand A/B save stage sitting between the operand input path and the ALU
// core. Operands are loaded from a packed bus with selectable half ordering,
// the ALU result is written back into A or B, and a DEPTH-entry LIFO keeps
// saved {A,B} pairs for undo / chained operations.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   active       load A/B from data_AB this cycle
//   data_AB      packed operands, upper half = first, lower half = second
//   pos_save     1: upper->A, lower->B, result->A ; 0: upper->B, lower->A, result->B
//   done         write data_result into the target register
//   data_result  ALU result
//   push         save current {A,B} on the LIFO
//   pop          restore {A,B} from the LIFO top
//   clr_err      clear the sticky error flag
//   data_outA    operand A register
//   data_outB    operand B register
//   valid        A/B hold loaded or restored data
//   count        LIFO occupancy
//   empty        count == 0
//   full         count == DEPTH
//   err          sticky flag for illegal push/pop requests
// ---------------------------------------------------------------------------
module operand_save_bank #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 active,
    input  logic [2*WIDTH-1:0]   data_AB,
    input  logic                 pos_save,
    input  logic                 done,
    input  logic [WIDTH-1:0]     data_result,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     data_outA,
    output logic [WIDTH-1:0]     data_outB,
    output logic                 valid,
    output logic [CW-1:0]        count,
    output logic                 empty,
    output logic                 full,
    output logic                 err
);

    // LIFO address width; a single-entry LIFO still needs a 1-bit index.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic               valid_reg, valid_next;
    logic [CW-1:0]      count_reg, count_next;
    logic               err_reg, err_next;

    logic [2*WIDTH-1:0] lifo [0:DEPTH-1];

    logic [WIDTH-1:0]   upper_half, lower_half;
    logic [WIDTH-1:0]   load_a, load_b;
    logic [2*WIDTH-1:0] lifo_top;
    logic [AW-1:0]      wr_idx, rd_idx;
    logic               is_empty, is_full;
    logic               do_push, do_pop, err_set;

    assign upper_half = data_AB[2*WIDTH-1:WIDTH];
    assign lower_half = data_AB[WIDTH-1:0];
    assign load_a     = pos_save ? upper_half : lower_half;
    assign load_b     = pos_save ? lower_half : upper_half;

    assign is_empty   = (count_reg == '0);
    assign is_full    = (count_reg == CW'(DEPTH));

    // Only a lone, legal request acts; simultaneous push+pop cancels both.
    assign do_push    = push & ~pop & ~is_full;
    assign do_pop     = pop & ~push & ~is_empty;
    assign err_set    = (push & pop) | (push & ~pop & is_full) | (pop & ~push & is_empty);

    // wr_idx is only used when not full, so count fits the address width.
    assign wr_idx     = count_reg[AW-1:0];
    assign rd_idx     = AW'(count_reg - CW'(1));
    assign lifo_top   = lifo[rd_idx];

    always_comb begin
        a_next     = a_reg;
        b_next     = b_reg;
        valid_next = valid_reg;
        count_next = count_reg;

        if (do_pop) begin
            // A successful restore overrides any load/writeback this cycle.
            a_next     = lifo_top[2*WIDTH-1:WIDTH];
            b_next     = lifo_top[WIDTH-1:0];
            valid_next = 1'b1;
            count_next = count_reg - CW'(1);
        end else begin
            if (active) begin
                a_next     = load_a;
                b_next     = load_b;
                valid_next = 1'b1;
            end
            // Writeback comes after load so the result wins on its target.
            if (done) begin
                if (pos_save) a_next = data_result;
                else          b_next = data_result;
            end
            if (do_push) count_next = count_reg + CW'(1);
        end

        // Set has priority over clear.
        err_next = err_set | (err_reg & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            valid_reg <= 1'b0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            a_reg     <= a_next;
            b_reg     <= b_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    // Storage needs no reset: contents are meaningless until pushed.
    // Push saves the pre-edge A/B, not the values being loaded this cycle.
    always_ff @(posedge clk) begin
        if (do_push) lifo[wr_idx] <= {a_reg, b_reg};
    end

    assign data_outA = a_reg;
    assign data_outB = b_reg;
    assign valid     = valid_reg;
    assign count     = count_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign err       = err_reg;

endmodule

// File: tb/tb_operand_save_bank.sv
module tb_operand_save_bank;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 active = 1'b0;
    logic [2*WIDTH-1:0]   data_AB = '0;
    logic                 pos_save = 1'b0;
    logic                 done = 1'b0;
    logic [WIDTH-1:0]     data_result = '0;
    logic                 push = 1'b0;
    logic                 pop = 1'b0;
    logic                 clr_err = 1'b0;
    logic [WIDTH-1:0]     data_outA, data_outB;
    logic                 valid, empty, full, err;
    logic [CW-1:0]        count;

    operand_save_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .active(active), .data_AB(data_AB),
        .pos_save(pos_save), .done(done), .data_result(data_result),
        .push(push), .pop(pop), .clr_err(clr_err),
        .data_outA(data_outA), .data_outB(data_outB), .valid(valid),
        .count(count), .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: two operand values, a queue used as a stack.
    logic [WIDTH-1:0]   m_a = '0, m_b = '0;
    logic               m_valid = 1'b0, m_err = 1'b0;
    logic [2*WIDTH-1:0] stack [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("A",     32'(data_outA), 32'(m_a));
        chk("B",     32'(data_outB), 32'(m_b));
        chk("valid", 32'(valid),     32'(m_valid));
        chk("count", 32'(count),     32'(stack.size()));
        chk("empty", 32'(empty),     32'(stack.size() == 0));
        chk("full",  32'(full),      32'(stack.size() == DEPTH));
        chk("err",   32'(err),       32'(m_err));
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_valid = 1'b0; m_err = 1'b0;
        stack.delete();
    endtask

    // One transaction: drive inputs, advance the model, clock, compare.
    task automatic step(input logic act, input logic [2*WIDTH-1:0] ab, input logic ps,
                        input logic dn, input logic [WIDTH-1:0] res,
                        input logic pu, input logic po, input logic ce);
        logic               bad;
        logic [2*WIDTH-1:0] top;
        logic [WIDTH-1:0]   hi, lo;
        active = act; data_AB = ab; pos_save = ps; done = dn; data_result = res;
        push = pu; pop = po; clr_err = ce;

        bad = 1'b0;
        hi = ab[2*WIDTH-1:WIDTH];
        lo = ab[WIDTH-1:0];
        if (pu && po) bad = 1'b1;
        else if (pu) begin
            if (stack.size() == DEPTH) bad = 1'b1;
            else stack.push_back({m_a, m_b});
        end
        if (po && !pu && stack.size() != 0) begin
            top = stack.pop_back();
            m_a = top[2*WIDTH-1:WIDTH];
            m_b = top[WIDTH-1:0];
            m_valid = 1'b1;
        end else begin
            if (po && !pu) bad = 1'b1;
            if (act) begin
                m_a = ps ? hi : lo;
                m_b = ps ? lo : hi;
                m_valid = 1'b1;
            end
            if (dn) begin
                if (ps) m_a = res; else m_b = res;
            end
        end
        if (bad) m_err = 1'b1;
        else if (ce) m_err = 1'b0;

        @(posedge clk);
        #1;
        $display("txn act=%0b ab=%h ps=%0b done=%0b res=%h push=%0b pop=%0b clr=%0b -> A=%h B=%h v=%0b cnt=%0d err=%0b",
                 act, ab, ps, dn, res, pu, po, ce, data_outA, data_outB, valid, count, err);
        compare_all();
    endtask

    initial begin
        // Asynchronous reset, released between clock edges.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_A", 32'(data_outA), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        compare_all();
        #9 rst_n = 1'b1;

        // Load ordering
        step(1, 8'hA5, 1, 0, 4'h0, 0, 0, 0);
        chk("load_ps1_A", 32'(data_outA), 32'hA);
        chk("load_ps1_B", 32'(data_outB), 32'h5);
        chk("load_valid", 32'(valid), 32'h1);
        step(1, 8'hA5, 0, 0, 4'h0, 0, 0, 0);
        chk("load_ps0_A", 32'(data_outA), 32'h5);
        chk("load_ps0_B", 32'(data_outB), 32'hA);

        // Writeback
        step(1, 8'h37, 1, 0, 4'h0, 0, 0, 0);
        step(0, 8'h00, 1, 1, 4'hC, 0, 0, 0);
        chk("wb_ps1_A", 32'(data_outA), 32'hC);
        chk("wb_ps1_B", 32'(data_outB), 32'h7);
        step(1, 8'h37, 1, 0, 4'h0, 0, 0, 0);
        step(0, 8'h00, 0, 1, 4'hC, 0, 0, 0);
        chk("wb_ps0_A", 32'(data_outA), 32'h3);
        chk("wb_ps0_B", 32'(data_outB), 32'hC);

        // Load and writeback together
        step(1, 8'h12, 1, 1, 4'hF, 0, 0, 0);
        chk("both_A", 32'(data_outA), 32'hF);
        chk("both_B", 32'(data_outB), 32'h2);

        // Push saves pre-edge values while a load proceeds
        step(1, 8'h12, 1, 0, 4'h0, 0, 0, 0);
        step(1, 8'h34, 1, 0, 4'h0, 1, 0, 0);
        chk("push_A", 32'(data_outA), 32'h3);
        chk("push_B", 32'(data_outB), 32'h4);
        chk("push_count", 32'(count), 32'h1);
        step(0, 8'h00, 1, 0, 4'h0, 0, 1, 0);
        chk("pop_A", 32'(data_outA), 32'h1);
        chk("pop_B", 32'(data_outB), 32'h2);
        chk("pop_empty", 32'(empty), 32'h1);

        // Overflow, clear, underflow
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 4'h0, 1, 0, 0);
        chk("ovf_count", 32'(count), 32'h4);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_err", 32'(err), 32'h1);
        step(0, 8'h00, 1, 0, 4'h0, 0, 0, 1);
        chk("clr_err", 32'(err), 32'h0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 4'h0, 0, 1, 0);
        step(1, 8'h9B, 1, 0, 4'h0, 0, 1, 0);
        chk("unf_err", 32'(err), 32'h1);
        chk("unf_count", 32'(count), 32'h0);
        chk("unf_load_A", 32'(data_outA), 32'h9);

        // push+pop together; clr with new error keeps err
        step(0, 8'h00, 1, 0, 4'h0, 0, 0, 1);
        step(1, 8'h5E, 0, 0, 4'h0, 1, 1, 1);
        chk("pp_err", 32'(err), 32'h1);
        chk("pp_count", 32'(count), 32'h0);

        // Mid-operation reset at count=2
        step(0, 8'h00, 1, 0, 4'h0, 0, 0, 1);
        step(1, 8'h6D, 1, 0, 4'h0, 1, 0, 0);
        step(0, 8'h00, 1, 0, 4'h0, 1, 0, 0);
        chk("pre_rst_count", 32'(count), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_A", 32'(data_outA), 32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        compare_all();
        #2 rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 4'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
